// File: rtl/fu_pkg.sv
// Shared definitions for the functional-unit dispatcher: opcodes, unit indices,
// FSM state encoding and opcode decode helpers.
package fu_pkg;

    localparam int unsigned OP_W      = 4;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned RES_W     = 64;
    localparam int unsigned MODE_W    = 3;
    localparam int unsigned NUM_UNITS = 5;

    localparam logic [OP_W-1:0] OP_UADD   = 4'd0;
    localparam logic [OP_W-1:0] OP_USUB   = 4'd1;
    localparam logic [OP_W-1:0] OP_UMUL   = 4'd2;
    localparam logic [OP_W-1:0] OP_UDIV   = 4'd3;
    localparam logic [OP_W-1:0] OP_SADD   = 4'd4;
    localparam logic [OP_W-1:0] OP_SSUB   = 4'd5;
    localparam logic [OP_W-1:0] OP_SMUL   = 4'd6;
    localparam logic [OP_W-1:0] OP_SDIV   = 4'd7;
    localparam logic [OP_W-1:0] OP_FADD   = 4'd8;
    localparam logic [OP_W-1:0] OP_FSUB   = 4'd9;
    localparam logic [OP_W-1:0] OP_FMUL   = 4'd10;
    localparam logic [OP_W-1:0] OP_FDIV   = 4'd11;
    localparam logic [OP_W-1:0] OP_ITOF_U = 4'd12;
    localparam logic [OP_W-1:0] OP_ITOF_S = 4'd13;

    localparam int unsigned U_ALU  = 0;
    localparam int unsigned U_FAS  = 1;
    localparam int unsigned U_FMUL = 2;
    localparam int unsigned U_FDIV = 3;
    localparam int unsigned U_ITF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // ALU add/sub finish in the ISSUE cycle; everything else needs cplt.
    function automatic logic OP_IS_COMB(input logic [OP_W-1:0] op);
        return (op == OP_UADD) || (op == OP_USUB) || (op == OP_SADD) || (op == OP_SSUB);
    endfunction

    // One-hot target unit; all-zero marks an illegal opcode.
    function automatic logic [NUM_UNITS-1:0] op_unit_mask(input logic [OP_W-1:0] op);
        logic [NUM_UNITS-1:0] m;
        m = '0;
        if (!op[3]) begin
            m[U_ALU] = 1'b1;
        end else begin
            case (op)
                OP_FADD, OP_FSUB:     m[U_FAS]  = 1'b1;
                OP_FMUL:              m[U_FMUL] = 1'b1;
                OP_FDIV:              m[U_FDIV] = 1'b1;
                OP_ITOF_U, OP_ITOF_S: m[U_ITF]  = 1'b1;
                default:              m = '0;
            endcase
        end
        return m;
    endfunction

    function automatic logic [MODE_W-1:0] op_mode(input logic [OP_W-1:0] op);
        if (!op[3]) begin
            return op[MODE_W-1:0];
        end
        return ((op == OP_FSUB) || (op == OP_ITOF_S)) ? MODE_W'(1) : MODE_W'(0);
    endfunction

endpackage

// File: rtl/fu_dispatch.sv
// Initiator side of the functional-unit enable/cplt handshake: issues one request
// at a time to the selected unit and returns its result on a valid/ready port.
module fu_dispatch
    import fu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [OP_W-1:0]      req_op,
    input  logic [DATA_W-1:0]    req_a,
    input  logic [DATA_W-1:0]    req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [RES_W-1:0]     rsp_data,
    output logic                 rsp_err,
    output logic                 cpu_isStop,
    output logic                 alu_en,
    output logic                 fas_en,
    output logic                 fmul_en,
    output logic                 fdiv_en,
    output logic                 itf_en,
    output logic [MODE_W-1:0]    fu_mode,
    output logic [DATA_W-1:0]    fu_x1,
    output logic [DATA_W-1:0]    fu_x2,
    input  logic [RES_W-1:0]     alu_y,
    input  logic [DATA_W-1:0]    fas_y,
    input  logic [DATA_W-1:0]    fmul_y,
    input  logic [DATA_W-1:0]    fdiv_y,
    input  logic [DATA_W-1:0]    itf_y,
    input  logic                 alu_cplt,
    input  logic                 fas_cplt,
    input  logic                 fmul_cplt,
    input  logic                 fdiv_cplt,
    input  logic                 itf_cplt
);

    state_t                 state;
    logic [OP_W-1:0]        op_q;
    logic [CNT_W-1:0]       cnt;
    logic [NUM_UNITS-1:0]   en_q;
    logic [NUM_UNITS-1:0]   req_mask;
    logic [NUM_UNITS-1:0]   sel_mask;
    logic [NUM_UNITS-1:0]   cplt_vec;
    logic                   sel_cplt;
    logic [RES_W-1:0]       sel_y;

    assign alu_en  = en_q[U_ALU];
    assign fas_en  = en_q[U_FAS];
    assign fmul_en = en_q[U_FMUL];
    assign fdiv_en = en_q[U_FDIV];
    assign itf_en  = en_q[U_ITF];

    assign req_mask = op_unit_mask(req_op);
    assign sel_mask = op_unit_mask(op_q);
    assign cplt_vec = {itf_cplt, fdiv_cplt, fmul_cplt, fas_cplt, alu_cplt};
    assign sel_cplt = |(sel_mask & cplt_vec);

    // Result mux for the unit owning the registered opcode; 32-bit results zero-extend.
    always_comb begin
        sel_y = '0;
        if (sel_mask[U_ALU]) begin
            sel_y = alu_y;
        end else if (sel_mask[U_FAS]) begin
            sel_y = RES_W'(fas_y);
        end else if (sel_mask[U_FMUL]) begin
            sel_y = RES_W'(fmul_y);
        end else if (sel_mask[U_FDIV]) begin
            sel_y = RES_W'(fdiv_y);
        end else if (sel_mask[U_ITF]) begin
            sel_y = RES_W'(itf_y);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            cnt        <= '0;
            en_q       <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_data   <= '0;
            cpu_isStop <= 1'b0;
            fu_mode    <= '0;
            fu_x1      <= '0;
            fu_x2      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q       <= req_op;
                        fu_x1      <= req_a;
                        fu_x2      <= req_b;
                        fu_mode    <= op_mode(req_op);
                        req_ready  <= 1'b0;
                        cpu_isStop <= 1'b1;
                        if (req_mask == '0) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            state     <= ST_RESP;
                        end else begin
                            en_q  <= req_mask;
                            state <= ST_ISSUE;
                        end
                    end
                end

                // cplt is not trusted here: it may be stale from a previous operation.
                ST_ISSUE: begin
                    if (OP_IS_COMB(op_q)) begin
                        rsp_data  <= sel_y;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        en_q      <= '0;
                        state     <= ST_RESP;
                    end else begin
                        cnt   <= '0;
                        state <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (sel_cplt) begin
                        rsp_data  <= sel_y;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        en_q      <= '0;
                        state     <= ST_RESP;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        en_q      <= '0;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        rsp_err    <= 1'b0;
                        req_ready  <= 1'b1;
                        cpu_isStop <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fu_dispatch.sv
// Scoreboard bench for fu_dispatch: behavioural unit models answer the enables,
// directed requests push expected responses, a negedge monitor pops and compares.
module tb_fu_dispatch;
    import fu_pkg::*;

    localparam int TO = 64;

    typedef struct {
        logic [63:0] data;
        logic        err;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                req_valid;
    logic                req_ready;
    logic [3:0]          req_op;
    logic [31:0]         req_a;
    logic [31:0]         req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [63:0]         rsp_data;
    logic                rsp_err;
    logic                cpu_isStop;
    logic                alu_en, fas_en, fmul_en, fdiv_en, itf_en;
    logic [2:0]          fu_mode;
    logic [31:0]         fu_x1, fu_x2;
    logic [63:0]         alu_y;
    logic [31:0]         fas_y, fmul_y, fdiv_y, itf_y;
    logic                alu_cplt, fas_cplt, fmul_cplt, fdiv_cplt, itf_cplt;

    logic [4:0]          en;
    logic [63:0]         uy[5];
    logic [63:0]         upend[5];
    logic                udone[5];
    int                  ustep[5];
    int                  ulat[5];
    logic                tie_fdiv;

    int                  total = 0;
    int                  bad = 0;
    exp_t                exp_q[$];
    int                  exp_unit;
    logic [2:0]          exp_mode;
    logic [31:0]         exp_a, exp_b;
    int                  en_cycles;
    int                  lat;

    fu_dispatch #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .cpu_isStop(cpu_isStop),
        .alu_en(alu_en), .fas_en(fas_en), .fmul_en(fmul_en), .fdiv_en(fdiv_en), .itf_en(itf_en),
        .fu_mode(fu_mode), .fu_x1(fu_x1), .fu_x2(fu_x2),
        .alu_y(alu_y), .fas_y(fas_y), .fmul_y(fmul_y), .fdiv_y(fdiv_y), .itf_y(itf_y),
        .alu_cplt(alu_cplt), .fas_cplt(fas_cplt), .fmul_cplt(fmul_cplt),
        .fdiv_cplt(fdiv_cplt), .itf_cplt(itf_cplt)
    );

    assign en        = {itf_en, fdiv_en, fmul_en, fas_en, alu_en};
    assign alu_y     = uy[0];
    assign fas_y     = uy[1][31:0];
    assign fmul_y    = uy[2][31:0];
    assign fdiv_y    = uy[3][31:0];
    assign itf_y     = uy[4][31:0];
    assign alu_cplt  = udone[0];
    assign fas_cplt  = udone[1];
    assign fmul_cplt = udone[2];
    assign fdiv_cplt = udone[3] & ~tie_fdiv;
    assign itf_cplt  = udone[4];

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Unit models: cplt is sticky after completion so a later ISSUE cycle sees it stale;
    // fmul/fdiv with a zero operand complete at step 0; lat 0 means combinational ALU.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            for (int u = 0; u < 5; u++) begin
                ustep[u] <= 0;
                udone[u] <= (u == 0);
                uy[u]    <= {32'hA5A5_0000 | 32'(u), 32'h5A5A_0000 | 32'(u)};
            end
        end else begin
            for (int u = 0; u < 5; u++) begin
                if (en[u]) begin
                    if (ustep[u] == 0) begin
                        if (ulat[u] == 0 || ((u == 2 || u == 3) && (fu_x1 == 0 || fu_x2 == 0))) begin
                            udone[u] <= 1'b1;
                            uy[u]    <= upend[u];
                        end else begin
                            udone[u] <= 1'b0;
                        end
                    end else if (ustep[u] + 1 == ulat[u]) begin
                        udone[u] <= 1'b1;
                        uy[u]    <= upend[u];
                    end
                    ustep[u] <= ustep[u] + 1;
                end else begin
                    ustep[u] <= 0;
                end
            end
        end
    end

    // Monitor: enable/operand checks while a unit is enabled, response pop on handshake.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (en != 5'd0) begin
                en_cycles++;
                check("en_select", 64'(en), 64'(1) << exp_unit);
                check("fu_mode", 64'(fu_mode), 64'(exp_mode));
                check("fu_x1", 64'(fu_x1), 64'(exp_a));
                check("fu_x2", 64'(fu_x2), 64'(exp_b));
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                end
            end
        end
    end

    task automatic wait_ready();
        int w = 0;
        while (!req_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (!req_ready) check("req_ready_timeout", 64'(req_ready), 64'(1));
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int unit, input logic [2:0] mode, input int ulatency,
                        input logic [63:0] y);
        wait_ready();
        exp_unit = unit;
        exp_mode = mode;
        exp_a    = a;
        exp_b    = b;
        if (unit < 5) begin
            ulat[unit]  = ulatency;
            upend[unit] = y;
            if (unit == 0 && ulatency == 0) uy[0] = y;
        end
        en_cycles = 0;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int unit, input logic [2:0] mode,
                          input int ulatency, input logic [63:0] y,
                          input logic [63:0] exp_data, input logic exp_err, input int exp_lat);
        exp_q.push_back('{exp_data, exp_err});
        send(op, a, b, unit, mode, ulatency, y);
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        tie_fdiv  = 1'b0;
        exp_unit  = 0;
        exp_mode  = '0;
        exp_a     = '0;
        exp_b     = '0;
        en_cycles = 0;
        for (int u = 0; u < 5; u++) begin
            ulat[u]  = 2;
            upend[u] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_err", 64'(rsp_err), 64'(0));
        check("rst_rsp_data", rsp_data, 64'(0));
        check("rst_stop", 64'(cpu_isStop), 64'(0));
        check("rst_en", 64'(en), 64'(0));
        check("rst_mode", 64'(fu_mode), 64'(0));
        rst = 1'b0;

        // fmul 2.0*3.0: enable held for ISSUE plus WAIT cycles until cplt
        run_op("fmul", OP_FMUL, 32'h4000_0000, 32'h4040_0000, 2, 3'd0, 5,
               64'h0000_0000_40C0_0000, 64'h0000_0000_40C0_0000, 1'b0, 7);
        check("fmul_en_cycles", 64'(en_cycles), 64'(6));

        run_op("udiv", OP_UDIV, 32'd7, 32'd2, 0, 3'd3, 4,
               64'h0000_0001_0000_0003, 64'h0000_0001_0000_0003, 1'b0, 6);

        // zero operand shortcut leaves fmul_cplt stale for the next fmul
        run_op("fmul_zero", OP_FMUL, 32'h0, 32'h4040_0000, 2, 3'd0, 5,
               64'h0, 64'h0, 1'b0, 3);

        run_op("sadd", OP_SADD, 32'hFFFF_FFFF, 32'd1, 0, 3'd4, 0,
               64'h0, 64'h0, 1'b0, 2);

        run_op("fmul_stale", OP_FMUL, 32'h4000_0000, 32'h4040_0000, 2, 3'd0, 3,
               64'h0000_0000_40C0_0000, 64'h0000_0000_40C0_0000, 1'b0, 5);

        run_op("fsub", OP_FSUB, 32'h4040_0000, 32'h4000_0000, 1, 3'd1, 2,
               64'h0000_0000_3F80_0000, 64'h0000_0000_3F80_0000, 1'b0, 4);

        // fdiv never completes: timeout error after TO WAIT cycles
        tie_fdiv = 1'b1;
        run_op("fdiv_timeout", OP_FDIV, 32'h4000_0000, 32'h4040_0000, 3, 3'd0, 2,
               64'h0000_0000_1234_5678, 64'h0, 1'b1, TO + 2);
        check("fdiv_en_after_timeout", 64'(fdiv_en), 64'(0));
        @(posedge clk); #1;
        tie_fdiv = 1'b0;

        // consumer stalls: response must hold
        rsp_ready = 1'b0;
        run_op("itof_s", OP_ITOF_S, 32'hFFFF_FFFF, 32'h0, 4, 3'd1, 3,
               64'h0000_0000_BF80_0000, 64'h0000_0000_BF80_0000, 1'b0, 5);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(rsp_valid), 64'(1));
            check("hold_data", rsp_data, 64'h0000_0000_BF80_0000);
            check("hold_req_ready", 64'(req_ready), 64'(0));
            check("hold_stop", 64'(cpu_isStop), 64'(1));
        end
        rsp_ready = 1'b1;

        // illegal opcode: exp_unit 7 makes any enable a mismatch in the monitor
        run_op("illegal", 4'd15, 32'h1, 32'h2, 7, 3'd0, 0, 64'h0, 64'h0, 1'b1, 1);

        // reset in the middle of an smul WAIT
        send(OP_SMUL, 32'hFFFF_FFFE, 32'd3, 0, 3'd6, 18, 64'hFFFF_FFFF_FFFF_FFFA);
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("smul_wait_en", 64'(alu_en), 64'(1));
        check("smul_wait_stop", 64'(cpu_isStop), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_en", 64'(en), 64'(0));
        check("midrst_req_ready", 64'(req_ready), 64'(1));
        check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("midrst_rsp_err", 64'(rsp_err), 64'(0));
        check("midrst_rsp_data", rsp_data, 64'(0));
        check("midrst_stop", 64'(cpu_isStop), 64'(0));
        check("midrst_mode", 64'(fu_mode), 64'(0));
        check("midrst_x1", 64'(fu_x1), 64'(0));
        check("midrst_x2", 64'(fu_x2), 64'(0));
        rst = 1'b0;

        run_op("uadd_after_rst", OP_UADD, 32'd5, 32'd6, 0, 3'd0, 0,
               64'd11, 64'd11, 1'b0, 2);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fu_dispatch.md
Name: fu_dispatch

Overview:
- Initiator side of the functional-unit enable/cplt handshake.
- Accepts one arithmetic request at a time from the CPU execute stage and selects the target unit: integer ALU, float add/sub, float mul, float div or int-to-float.
- Holds that unit's enable, waits for cplt, captures the result, drops enable so the unit returns to idle, then presents the result on a valid/ready response port.
- Drives the CPU stall line while an operation is in flight.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles in WAIT before abort; must exceed the slowest unit (signed int mul, 18 cycles).
- CNT_W, 7: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  dispatcher can accept a request.
- req_op  in  4  opcode: 0-7 integer ALU mode (0 uadd, 1 usub, 2 umul, 3 udiv, 4 sadd, 5 ssub, 6 smul, 7 sdiv); 8 fadd; 9 fsub; 10 fmul; 11 fdiv; 12 itof unsigned; 13 itof signed; 14-15 illegal.
- req_a, req_b  in  32  operands.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_data  out  64  result; float and itof results are zero-extended to 64 bits.
- rsp_err  out  1  qualifies rsp_valid: illegal opcode or timeout.
- cpu_isStop  out  1  high whenever state != IDLE.
- alu_en, fas_en, fmul_en, fdiv_en, itf_en  out  1 each  one-hot unit enables.
- fu_mode  out  3  ALU mode (0-7), fas mode (0 add, 1 sub), itf mode (0 unsigned, 1 signed).
- fu_x1, fu_x2  out  32  registered operands.
- alu_y  in  64; fas_y, fmul_y, fdiv_y, itf_y  in  32  unit results.
- alu_cplt, fas_cplt, fmul_cplt, fdiv_cplt, itf_cplt  in  1  unit completion flags.

Behaviour:
- Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, all enables 0, fu_mode=0, fu_x1=fu_x2=0, cpu_isStop=0, counter=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register op, a and b.
  - Illegal op (14-15): go to RESP with rsp_err=1 and rsp_data=0.
  - Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Selected enable=1.
  - Combinational ops (0, 1, 4, 5): capture alu_y this cycle and go to RESP.
  - All other ops: ignore the selected cplt this cycle, because the unit's cplt may be stale from a previous zero-operand shortcut or the ALU's idle cplt=1. Go to WAIT with counter=0.
- WAIT:
  - Enable held high; counter increments each cycle.
  - First cycle with the selected cplt=1: capture the selected y into rsp_data, drop the enable (registered low from the next cycle), go to RESP.
  - When the counter reaches TIMEOUT_CYCLES without cplt: drop the enable, rsp_err=1, rsp_data=0, go to RESP.
- RESP:
  - rsp_valid=1 and all enables 0.
  - rsp_data and rsp_err stay stable until rsp_valid & rsp_ready.
  - On that handshake go to IDLE and clear rsp_valid and rsp_err.
- Enable-low gap: RESP lasts at least 1 cycle, so every unit sees enable low for at least one cycle between operations and returns to its idle step.
- Latency, counting request acceptance as cycle 0:
  - Combinational ALU ops: rsp_valid at cycle 2.
  - Multi-cycle ops: rsp_valid 1 cycle after the cplt sample.
- Zero-operand shortcut (fmul/fdiv): cplt is seen in the first WAIT cycle while the unit is still at step 0; capturing then is correct.
- Only one enable may be high at any time; fu_x1, fu_x2 and fu_mode are constant from ISSUE until leaving WAIT.
- req_ready=0 in every state except IDLE; requests are not queued.
- rst high in any state returns to the reset values on the next edge, including mid-WAIT. The enable falls on that edge, so the unit self-clears.
- cpu_isStop is a registered decode of state != IDLE.

Decomposition:
- Shared package fu_pkg:
  - opcode localparams OP_UADD through OP_ITOF_S;
  - OP_IS_COMB(op) decode;
  - state encoding.
- No sub-module: the one-hot enable decode and the result mux stay inline.

Test Plan:
- fmul a=0x40000000 (2.0), b=0x40400000 (3.0) -> rsp_data=0x00000000_40C00000, rsp_err=0; fmul_en high for one ISSUE cycle plus the WAIT cycles until fmul_cplt.
- udiv a=7, b=2 -> rsp_data=0x00000001_00000003 (remainder in the upper word).
- sadd a=0xFFFFFFFF, b=1 -> rsp_data=0, rsp_valid at cycle 2; a preceding fmul with a=0 leaves stale cplt, and the next fmul 2.0*3.0 still returns 0x40C00000.
- Tie fdiv_cplt=0 and issue fdiv -> after TIMEOUT_CYCLES, rsp_err=1, rsp_data=0, fdiv_en low.
- Hold rsp_ready=0 for 10 cycles after itof signed a=0xFFFFFFFF -> rsp_data=0xBF800000 stable, req_ready=0, cpu_isStop=1 throughout.
- op=15 -> rsp_err=1 in RESP with no enable ever asserted; rst asserted mid-WAIT of smul -> all outputs at reset values the next cycle.
